// File: rtl/mem_copy_dma_if.sv
// ----------------------------------------------------------------------------
// mem_copy_dma_if
// Bundles the control handshake and the data-memory bus of the word-copy DMA.
//
// Control side
//   start       request pulse (only honoured while the DMA is idle)
//   src_addr    byte address of the first source word
//   dst_addr    byte address of the first destination word
//   len         number of 32-bit words to copy
//   busy        high while a copy (or its completion cycle) is in progress
//   done        one-cycle pulse on successful completion
//   err         one-cycle pulse when a start is rejected for misalignment
//   words_left  words not yet written
// Memory side
//   mem_rd / mem_wr      read / write enables (never high together)
//   mem_addr             word-aligned byte address while an access is active
//   mem_wdata            write data
//   mem_rdata            read data, combinational from mem_addr/mem_rd
//
// Modports: master = the DMA engine, slave = the system around it
// (requester plus data memory).
// ----------------------------------------------------------------------------
interface mem_copy_dma_if #(
  parameter int LEN_W  = 8,
  parameter int ADDR_W = 32
);

  logic              start;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic              done;
  logic              err;
  logic [LEN_W-1:0]  words_left;

  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    input  start, src_addr, dst_addr, len, mem_rdata,
    output busy, done, err, words_left, mem_rd, mem_wr, mem_addr, mem_wdata
  );

  modport slave (
    output start, src_addr, dst_addr, len, mem_rdata,
    input  busy, done, err, words_left, mem_rd, mem_wr, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_copy_dma.sv
// ----------------------------------------------------------------------------
// mem_copy_dma
// Copies len 32-bit words from src_addr to dst_addr in ascending order, one
// read cycle followed by one write cycle per word, through a single-port data
// memory with combinational read data.
//
// Ports
//   clk    single clock, all state changes on its rising edge
//   reset  asynchronous, active-low reset
//   bus    mem_copy_dma_if.master: control handshake plus data-memory bus
//
// Behaviour summary
//   IDLE  : waits for start. Misaligned src/dst -> err pulse next cycle, no
//           state change. len==0 -> straight to DONE. Otherwise latch the
//           request and go to READ.
//   READ  : mem_rd with the source pointer; read data is captured on exit.
//   WRITE : mem_wr with the destination pointer and the captured word; both
//           pointers advance by 4 and words_left decrements on exit.
//   DONE  : one cycle with done high, then back to IDLE.
// Because each read happens after all earlier writes of the same copy have
// landed, overlapping regions see already-updated memory contents.
// ----------------------------------------------------------------------------
module mem_copy_dma #(
  parameter int LEN_W  = 8,
  parameter int ADDR_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  mem_copy_dma_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q,     state_d;
  logic [ADDR_W-1:0] src_q,       src_d;
  logic [ADDR_W-1:0] dst_q,       dst_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [LEN_W-1:0]  left_q,      left_d;
  logic [31:0]       hold_q,      hold_d;
  logic              err_q,       err_d;

  logic              rd_c;
  logic              wr_c;
  logic [ADDR_W-1:0] addr_c;
  logic              aligned;

  assign aligned = (bus.src_addr[1:0] == 2'b00) && (bus.dst_addr[1:0] == 2'b00);

  // Next-state and memory-bus decode.
  // NOTE: every variable written here gets its default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    last_addr_d = last_addr_q;
    left_d      = left_q;
    hold_d      = hold_q;
    err_d       = 1'b0;
    rd_c        = 1'b0;
    wr_c        = 1'b0;
    addr_c      = last_addr_q;   // bus address parks on its last driven value

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (aligned) begin
            src_d   = bus.src_addr;
            dst_d   = bus.dst_addr;
            left_d  = bus.len;
            state_d = (bus.len == '0) ? DONE : READ;
          end else begin
            // Rejected request: no state change, words_left untouched.
            err_d = 1'b1;
          end
        end
      end

      READ: begin
        rd_c        = 1'b1;
        addr_c      = src_q;
        last_addr_d = src_q;
        hold_d      = bus.mem_rdata;
        state_d     = WRITE;
      end

      WRITE: begin
        wr_c        = 1'b1;
        addr_c      = dst_q;
        last_addr_d = dst_q;
        src_d       = src_q + ADDR_W'(4);
        dst_d       = dst_q + ADDR_W'(4);
        left_d      = left_q - LEN_W'(1);
        state_d     = (left_q == LEN_W'(1)) ? DONE : READ;
      end

      DONE: begin
        // start is deliberately not looked at here.
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers.
  // NOTE: the holding register is a single 32-bit flop, not a RAM array, so it
  // is cleared by reset together with the pointers and the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_q       <= '0;
      dst_q       <= '0;
      last_addr_q <= '0;
      left_q      <= '0;
      hold_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      src_q       <= src_d;
      dst_q       <= dst_d;
      last_addr_q <= last_addr_d;
      left_q      <= left_d;
      hold_q      <= hold_d;
      err_q       <= err_d;
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.err        = err_q;
  assign bus.words_left = left_q;
  assign bus.mem_rd     = rd_c;
  assign bus.mem_wr     = wr_c;
  assign bus.mem_addr   = addr_c;
  // The holding register only changes on READ exit, so it already shows the
  // word being written in WRITE and keeps that word afterwards.
  assign bus.mem_wdata  = hold_q;

endmodule

// File: tb/tb_mem_copy_dma.sv
// ----------------------------------------------------------------------------
// tb_mem_copy_dma
// Directed bench for mem_copy_dma with a 64-word behavioural data memory.
// Inputs are driven 1 time unit after a rising edge; outputs are sampled on
// the falling edge of the cycle of interest. "edge 0" is the rising edge
// that samples start.
// ----------------------------------------------------------------------------
module tb_mem_copy_dma;

  localparam int LEN_W  = 8;
  localparam int ADDR_W = 32;

  logic clk;
  logic reset;

  mem_copy_dma_if #(.LEN_W(LEN_W), .ADDR_W(ADDR_W)) bus ();

  mem_copy_dma #(.LEN_W(LEN_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: combinational read, write on the rising edge.
  // The bench preloads words through the tb_we port while the DMA is idle.
  logic [31:0] mem [64];
  logic        tb_we;
  logic [5:0]  tb_wa;
  logic [31:0] tb_wd;

  assign bus.mem_rdata = bus.mem_rd ? mem[bus.mem_addr[7:2]] : 32'h0;

  always @(posedge clk) begin
    if (bus.mem_wr)  mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    else if (tb_we)  mem[tb_wa] <= tb_wd;
  end

  // Per-cycle activity counters, sampled mid-cycle.
  int rd_cnt   = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;

  always @(negedge clk) begin
    if (bus.mem_rd === 1'b1) rd_cnt++;
    if (bus.mem_wr === 1'b1) wr_cnt++;
    if (bus.done   === 1'b1) done_cnt++;
    if (bus.err    === 1'b1) err_cnt++;
    if (bus.mem_rd === 1'b1 && bus.mem_wr === 1'b1) both_cnt++;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input int widx, input logic [31:0] data);
    tb_wa = 6'(widx);
    tb_wd = data;
    tb_we = 1'b1;
    tick();
    tb_we = 1'b0;
  endtask

  // Presents a request; returns 1 unit after edge 0.
  task automatic start_copy(input logic [31:0] src, input logic [31:0] dst,
                            input logic [7:0] n);
    bus.start    = 1'b1;
    bus.src_addr = src;
    bus.dst_addr = dst;
    bus.len      = n;
    tick();
    bus.start    = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    #2;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 ||
        bus.mem_rd !== 1'b0 || bus.mem_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy=%b done=%b err=%b rd=%b wr=%b, want all 0",
               bus.busy, bus.done, bus.err, bus.mem_rd, bus.mem_wr);
    end
    n_tests++;
    if (bus.words_left !== 8'd0 || bus.mem_addr !== 32'd0 || bus.mem_wdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_data: words_left=%0d addr=%h wdata=%h, want 0 0 0",
               bus.words_left, bus.mem_addr, bus.mem_wdata);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_copy();
    logic [31:0] exp_data [4];
    int rd0, wr0, dn0;
    exp_data = '{32'd11, 32'd22, 32'd33, 32'd44};
    for (int i = 0; i < 4; i++) poke(i, exp_data[i]);
    for (int i = 4; i < 8; i++) poke(i, 32'd0);
    rd0 = rd_cnt; wr0 = wr_cnt; dn0 = done_cnt;

    start_copy(32'd0, 32'd16, 8'd4);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k % 2 == 0) begin
        n_tests++;
        if (bus.mem_rd !== 1'b1 || bus.mem_wr !== 1'b0 ||
            bus.mem_addr !== 32'(4 * (k / 2)) || bus.words_left !== 8'(4 - k / 2)) begin
          n_fail++;
          $display("FAIL copy_read k=%0d: rd=%b wr=%b addr=%0d left=%0d, want rd=1 wr=0 addr=%0d left=%0d",
                   k, bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.words_left,
                   4 * (k / 2), 4 - k / 2);
        end
      end else begin
        n_tests++;
        if (bus.mem_wr !== 1'b1 || bus.mem_rd !== 1'b0 ||
            bus.mem_addr !== 32'(16 + 4 * (k / 2)) || bus.mem_wdata !== exp_data[k / 2]) begin
          n_fail++;
          $display("FAIL copy_write k=%0d: wr=%b rd=%b addr=%0d wdata=%0d, want wr=1 rd=0 addr=%0d wdata=%0d",
                   k, bus.mem_wr, bus.mem_rd, bus.mem_addr, bus.mem_wdata,
                   16 + 4 * (k / 2), exp_data[k / 2]);
        end
      end
      tick();
    end

    // cycle after edge 8
    @(negedge clk);
    n_tests++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.words_left !== 8'd0) begin
      n_fail++;
      $display("FAIL copy_done: done=%b busy=%b left=%0d, want 1 1 0",
               bus.done, bus.busy, bus.words_left);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.mem_addr !== 32'd28 ||
        bus.mem_wdata !== 32'd44) begin
      n_fail++;
      $display("FAIL copy_idle_hold: done=%b busy=%b addr=%0d wdata=%0d, want 0 0 28 44",
               bus.done, bus.busy, bus.mem_addr, bus.mem_wdata);
    end
    tick();
    n_tests++;
    if (rd_cnt - rd0 != 4 || wr_cnt - wr0 != 4 || done_cnt - dn0 != 1) begin
      n_fail++;
      $display("FAIL copy_counts: rd=%0d wr=%0d done=%0d, want 4 4 1",
               rd_cnt - rd0, wr_cnt - wr0, done_cnt - dn0);
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (mem[4 + i] !== exp_data[i]) begin
        n_fail++;
        $display("FAIL copy_mem word %0d: got %0d, want %0d", 4 + i, mem[4 + i], exp_data[i]);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_zero_len();
    int rd0, wr0;
    rd0 = rd_cnt; wr0 = wr_cnt;
    start_copy(32'd0, 32'd8, 8'd0);
    @(negedge clk);
    n_tests++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.mem_rd !== 1'b0 || bus.mem_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_len_done: done=%b busy=%b rd=%b wr=%b, want 1 1 0 0",
               bus.done, bus.busy, bus.mem_rd, bus.mem_wr);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_len_idle: done=%b busy=%b, want 0 0", bus.done, bus.busy);
    end
    tick();
    n_tests++;
    if (rd_cnt != rd0 || wr_cnt != wr0) begin
      n_fail++;
      $display("FAIL zero_len_access: rd=%0d wr=%0d, want 0 0", rd_cnt - rd0, wr_cnt - wr0);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_misaligned();
    int rd0, wr0, er0;
    rd0 = rd_cnt; wr0 = wr_cnt; er0 = err_cnt;
    start_copy(32'd2, 32'd8, 8'd3);
    @(negedge clk);
    n_tests++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.words_left !== 8'd0) begin
      n_fail++;
      $display("FAIL misalign_src: err=%b busy=%b left=%0d, want 1 0 0",
               bus.err, bus.busy, bus.words_left);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_pulse: err=%b busy=%b, want 0 0", bus.err, bus.busy);
    end
    tick();
    start_copy(32'd0, 32'd9, 8'd1);
    @(negedge clk);
    n_tests++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_dst: err=%b busy=%b, want 1 0", bus.err, bus.busy);
    end
    tick();
    n_tests++;
    if (rd_cnt != rd0 || wr_cnt != wr0 || err_cnt - er0 != 2) begin
      n_fail++;
      $display("FAIL misalign_counts: rd=%0d wr=%0d err=%0d, want 0 0 2",
               rd_cnt - rd0, wr_cnt - wr0, err_cnt - er0);
    end

    // An aligned request right afterwards is accepted.
    start_copy(32'd0, 32'd32, 8'd1);
    @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b1 || bus.mem_rd !== 1'b1 || bus.mem_addr !== 32'd0 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_recover: busy=%b rd=%b addr=%0d err=%b, want 1 1 0 0",
               bus.busy, bus.mem_rd, bus.mem_addr, bus.err);
    end
    tick();
    tick();
    @(negedge clk);
    n_tests++;
    if (bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL misalign_recover_done: done=%b, want 1", bus.done);
    end
    tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_overlap();
    poke(0, 32'd5);
    poke(1, 32'd6);
    poke(2, 32'd77);
    start_copy(32'd0, 32'd4, 8'd2);
    for (int i = 0; i < 6; i++) tick();
    n_tests++;
    if (mem[0] !== 32'd5 || mem[1] !== 32'd5 || mem[2] !== 32'd5) begin
      n_fail++;
      $display("FAIL overlap_mem: words0..2=%0d,%0d,%0d, want 5,5,5", mem[0], mem[1], mem[2]);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_ignore_start();
    int rd0, wr0, dn0;
    poke(10, 32'd0);
    poke(11, 32'd0);
    poke(12, 32'd0);
    rd0 = rd_cnt; wr0 = wr_cnt; dn0 = done_cnt;
    start_copy(32'd0, 32'd40, 8'd3);        // edge 0
    tick();                                  // edge 1 -> in WRITE
    bus.start = 1'b1; bus.src_addr = 32'd4; bus.dst_addr = 32'd48; bus.len = 8'd5;
    tick();                                  // edge 2 samples it in WRITE
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();      // edge 6 -> DONE
    bus.start = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL ignore_done_cycle: done=%b, want 1", bus.done);
    end
    tick();                                  // edge 7 samples it in DONE
    bus.start = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_after_done: busy=%b done=%b, want 0 0", bus.busy, bus.done);
    end
    for (int i = 0; i < 3; i++) tick();
    n_tests++;
    if (rd_cnt - rd0 != 3 || wr_cnt - wr0 != 3 || done_cnt - dn0 != 1) begin
      n_fail++;
      $display("FAIL ignore_counts: rd=%0d wr=%0d done=%0d, want 3 3 1",
               rd_cnt - rd0, wr_cnt - wr0, done_cnt - dn0);
    end
    n_tests++;
    if (mem[10] !== 32'd5 || mem[11] !== 32'd5 || mem[12] !== 32'd5) begin
      n_fail++;
      $display("FAIL ignore_mem: words10..12=%0d,%0d,%0d, want 5,5,5", mem[10], mem[11], mem[12]);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_mid();
    int wr0, dn0;
    for (int i = 0; i < 4; i++) poke(i, 32'(i + 1));
    for (int i = 20; i < 24; i++) poke(i, 32'd0);
    poke(24, 32'd0);
    wr0 = wr_cnt; dn0 = done_cnt;
    start_copy(32'd0, 32'd80, 8'd4);        // edge 0
    tick();                                  // edge 1
    tick();                                  // edge 2 -> second READ
    #2;
    reset = 1'b0;
    #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 ||
        bus.mem_rd !== 1'b0 || bus.mem_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_ctrl: busy=%b done=%b err=%b rd=%b wr=%b, want all 0",
               bus.busy, bus.done, bus.err, bus.mem_rd, bus.mem_wr);
    end
    n_tests++;
    if (bus.words_left !== 8'd0 || bus.mem_addr !== 32'd0 || bus.mem_wdata !== 32'd0) begin
      n_fail++;
      $display("FAIL midreset_data: left=%0d addr=%h wdata=%h, want 0 0 0",
               bus.words_left, bus.mem_addr, bus.mem_wdata);
    end
    tick();
    tick();
    n_tests++;
    if (wr_cnt - wr0 != 1 || done_cnt != dn0 || mem[20] !== 32'd1 || mem[21] !== 32'd0) begin
      n_fail++;
      $display("FAIL midreset_abort: wr=%0d done=%0d w20=%0d w21=%0d, want 1 0 1 0",
               wr_cnt - wr0, done_cnt - dn0, mem[20], mem[21]);
    end

    // Release reset mid-cycle; the very next rising edge takes the request.
    #2;
    reset = 1'b1;
    bus.start = 1'b1; bus.src_addr = 32'd12; bus.dst_addr = 32'd96; bus.len = 8'd1;
    tick();
    bus.start = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b1 || bus.mem_rd !== 1'b1 || bus.mem_addr !== 32'd12) begin
      n_fail++;
      $display("FAIL post_reset_start: busy=%b rd=%b addr=%0d, want 1 1 12",
               bus.busy, bus.mem_rd, bus.mem_addr);
    end
    tick();
    tick();
    @(negedge clk);
    n_tests++;
    if (bus.done !== 1'b1 || mem[24] !== 32'd4) begin
      n_fail++;
      $display("FAIL post_reset_copy: done=%b w24=%0d, want 1 4", bus.done, mem[24]);
    end
    tick();
  endtask

  // --------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b0;
    tb_we        = 1'b0;
    tb_wa        = '0;
    tb_wd        = '0;
    bus.start    = 1'b0;
    bus.src_addr = '0;
    bus.dst_addr = '0;
    bus.len      = '0;

    test_reset();
    for (int i = 0; i < 64; i++) poke(i, 32'd0);
    reset = 1'b1;
    tick();

    test_copy();
    test_zero_len();
    test_misaligned();
    test_overlap();
    test_ignore_start();
    test_reset_mid();

    n_tests++;
    if (both_cnt != 0) begin
      n_fail++;
      $display("FAIL rd_wr_exclusive: cycles with both high=%0d, want 0", both_cnt);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
